// File: rtl/uart_dbg_pkg.sv
// uart_dbg_pkg: shared FSM encoding, defaults and index width for the UART word arbiter
package uart_dbg_pkg;
   typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
   localparam int DEF_TIMEOUT_CYC = 1000000;
   localparam int DEF_GAP_CYC     = 2;
   localparam int IDXW            = 3;
endpackage

// File: rtl/uart_word_arbiter_if.sv
// uart_word_arbiter_if: requester and transmitter handshake bundle
// master (arbiter side): in req, word_in, word_send; out done, err, busy, grant_id, addr_query, addr
// slave (requesters/transmitter side): the mirror image
interface uart_word_arbiter_if import uart_dbg_pkg::*; #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]      req;
   logic [32*NREQ-1:0]   word_in;
   logic [NREQ-1:0]      done;
   logic [NREQ-1:0]      err;
   logic                 busy;
   logic [IDXW-1:0]      grant_id;
   logic                 addr_query;
   logic [31:0]          addr;
   logic                 word_send;
   modport master(input req, word_in, word_send, output done, err, busy, grant_id, addr_query, addr);
   modport slave(output req, word_in, word_send, input done, err, busy, grant_id, addr_query, addr);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set req bit from ptr upward with wrap
// req: request bits; ptr: highest-priority index; gnt: one-hot grant; idx: granted index
module rr_arbiter import uart_dbg_pkg::*; #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDXW-1:0] idx
);
   localparam logic [IDXW:0] NR = (IDXW+1)'(NREQ);
   logic [NREQ-1:0] rot;
   logic [IDXW:0]   s;
   logic            hit;
   always_comb begin
      rot = NREQ'({req, req} >> ptr);
      idx = '0;
      hit = 1'b0;
      s   = '0;
      gnt = '0;
      // descending scan: the lowest rotated position is written last and wins
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            hit = 1'b1;
            s   = {1'b0, ptr} + (IDXW+1)'(i);
            idx = s >= NR ? IDXW'(s - NR) : IDXW'(s);
         end
      end
      for (int k = 0; k < NREQ; k++) gnt[k] = hit && idx == IDXW'(k);
   end
endmodule

// File: rtl/uart_word_arbiter.sv
// uart_word_arbiter: round-robin share of one 32-bit word UART transmitter among NREQ requesters
// clk, reset (async active-low); bus: requester req/word_in/done/err, status busy/grant_id,
// transmitter addr_query/addr/word_send
module uart_word_arbiter import uart_dbg_pkg::*; #(
   parameter int NREQ        = 4,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int GAP_CYC     = DEF_GAP_CYC
) (
   input logic                 clk,
   input logic                 reset,
   uart_word_arbiter_if.master bus
);
   localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
   localparam int RW = NREQ > 1 ? $clog2(NREQ) : 1;
   localparam int WW = $clog2(32 * NREQ);
   localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] CMAX  = CW'(TIMEOUT_CYC);
   logic [1:0]      rs_q;
   logic            rst_n;
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [IDXW-1:0] rr_q, rr_d, gid_q, gid_d, pick;
   logic [31:0]     addr_q, addr_d;
   logic            aq_q, aq_d, busy_q, busy_d, tmo;
   logic [NREQ-1:0] done_q, done_d, err_q, err_d, gnt;
   // reset asserts immediately, releases two edges later in step with clk
   always_ff @(posedge clk or negedge reset)
      if (!reset) rs_q <= 2'b00;
      else rs_q <= {rs_q[0], 1'b1};
   assign rst_n = rs_q[1];
   rr_arbiter #(.NREQ(NREQ)) u_rr (.req(bus.req), .ptr(rr_q), .gnt(gnt), .idx(pick));
   assign tmo = TIMEOUT_CYC != 0 && cnt_q == TLAST;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      rr_d    = rr_q;
      gid_d   = gid_q;
      addr_d  = addr_q;
      aq_d    = aq_q;
      busy_d  = busy_q;
      done_d  = '0;
      err_d   = '0;
      case (state_q)
         IDLE: if (|gnt) begin
            state_d = XFER;
            gid_d   = pick;
            addr_d  = bus.word_in[WW'({pick, 5'd0}) +: 32];
            aq_d    = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = '0;
         end
         XFER: begin
            cnt_d = cnt_q == CMAX ? cnt_q : cnt_q + 1'b1;
            // word_send takes precedence over a coincident timeout
            if (bus.word_send || tmo) begin
               state_d = GAP;
               aq_d    = 1'b0;
               gap_d   = '0;
               rr_d    = gid_q == IDXW'(NREQ - 1) ? '0 : gid_q + 1'b1;
               done_d[RW'(gid_q)] = bus.word_send;
               err_d[RW'(gid_q)]  = !bus.word_send;
            end
         end
         GAP: begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GW'(GAP_CYC - 1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gap_q   <= '0;
         rr_q    <= '0;
         gid_q   <= '0;
         addr_q  <= '0;
         aq_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         rr_q    <= rr_d;
         gid_q   <= gid_d;
         addr_q  <= addr_d;
         aq_q    <= aq_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.busy       = busy_q;
   assign bus.grant_id   = gid_q;
   assign bus.addr_query = aq_q;
   assign bus.addr       = addr_q;
endmodule
